clock_display_top: RTL and testbench

Top level of a 24-hour HH:MM digital clock driving a 4-digit multiplexed 7-segment display, with two push buttons (Set, Up) for time setting. It contains:
- button debouncers with rising-edge pulse generation
- a 1 Hz prescaler
- HH:MM:SS time counters
- a 4-state mode FSM
- a digit scanner with segment decoder
It sits directly between board pins and the system clock.

---
 rtl/clock_display_top.sv | 226 ++++++++++++++++++++++
 tb/tb_clock_display_top.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_display_top.sv
// clock_display_top
// 24-hour HH:MM clock for a 4-digit multiplexed 7-segment display, set with
// two push buttons. Contains a reset synchronizer, button synchronizers and
// debouncers, a 1 Hz prescaler, HH:MM:SS counters, a 4-state mode FSM
// (NORMAL -> RESET_SEC -> SET_MIN -> SET_HOUR), a blink counter and a digit
// scanner with segment decoder.
//
// Ports:
//   i_Clock       system clock, all logic on the rising edge
//   i_Reset_n     asynchronous active-low reset (released synchronously)
//   i_Button_Set  Set button, active-high, raw and bouncy
//   i_Button_Up   Up button, active-high, raw and bouncy
//   o_Segments    bit7 = dot, bits6:0 = g,f,e,d,c,b,a (active-high)
//   o_Digits      one-hot digit enable: [3] hours tens .. [0] minutes units
//
// Optional feature macro: COLON_BLINK_EN
//   defined   -> in NORMAL the dot on digit[2] lights in the first half of
//                each second (1 Hz colon)
//   undefined -> the dot is never lit
module clock_display_top #(
  parameter int CLK_HZ          = 32768,
  parameter int DEBOUNCE_CYCLES = 512,
  parameter int SCAN_CYCLES     = 32
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Button_Set,
  input  logic       i_Button_Up,
  output logic [7:0] o_Segments,
  output logic [3:0] o_Digits
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_CYCLES + 1);

  typedef enum logic [1:0] {NORMAL, RESET_SEC, SET_MIN, SET_HOUR} mode_e;

  logic [1:0]    rstSync_q;
  logic          rstInt_n;
  logic [1:0]    btnRaw;
  logic [1:0]    btnMeta_q, btnSync_q, btnLevel_q, btnLevelDly_q;
  logic [DW-1:0] dbCnt_q [2];
  logic          setPulse, upPulse;
  mode_e         mode_q;
  logic [4:0]    hr_q;
  logic [5:0]    min_q, sec_q;
  logic [PW-1:0] presc_q, blink_q;
  logic          tick, blinkOff;
  logic [SW-1:0] scanCnt_q;
  logic [1:0]    scanIdx_q;
  logic [3:0]    digVal;
  logic          blank, dot;
  logic [3:0]    digits_d;
  logic [7:0]    segments_d;

  // Reset asserts immediately but is released only on a clock edge.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) rstSync_q <= '0;
    else            rstSync_q <= {rstSync_q[0], 1'b1};
  end
  assign rstInt_n = rstSync_q[1];

  // Bit 0 is Set, bit 1 is Up.
  assign btnRaw = {i_Button_Up, i_Button_Set};

  // Two-flop synchronizer, then a debouncer per button: the level flips only
  // after DEBOUNCE_CYCLES samples in a row that differ from it; a sample that
  // agrees with the current level restarts the count.
  always_ff @(posedge i_Clock or negedge rstInt_n) begin
    if (!rstInt_n) begin
      btnMeta_q     <= '0;
      btnSync_q     <= '0;
      btnLevel_q    <= '0;
      btnLevelDly_q <= '0;
      dbCnt_q[0]    <= '0;
      dbCnt_q[1]    <= '0;
    end else begin
      btnMeta_q     <= btnRaw;
      btnSync_q     <= btnMeta_q;
      btnLevelDly_q <= btnLevel_q;
      for (int b = 0; b < 2; b++) begin
        if (btnSync_q[b] == btnLevel_q[b]) begin
          dbCnt_q[b] <= '0;
        end else if (dbCnt_q[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
          btnLevel_q[b] <= btnSync_q[b];
          dbCnt_q[b]    <= '0;
        end else begin
          dbCnt_q[b] <= dbCnt_q[b] + DW'(1);
        end
      end
    end
  end

  // Set wins when both buttons pulse together.
  assign setPulse = btnLevel_q[0] & ~btnLevelDly_q[0];
  assign upPulse  = btnLevel_q[1] & ~btnLevelDly_q[1] & ~setPulse;
  assign tick     = (presc_q == PW'(CLK_HZ - 1));

  // Mode FSM with timekeeping. The clock runs in NORMAL and RESET_SEC;
  // the later mode-specific assignments override the running count.
  always_ff @(posedge i_Clock or negedge rstInt_n) begin
    if (!rstInt_n) begin
      mode_q  <= NORMAL;
      hr_q    <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      presc_q <= '0;
    end else begin
      if (mode_q == NORMAL || mode_q == RESET_SEC) begin
        if (tick) begin
          presc_q <= '0;
          if (sec_q == 6'd59) begin
            sec_q <= '0;
            if (min_q == 6'd59) begin
              min_q <= '0;
              hr_q  <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_q <= min_q + 6'd1;
            end
          end else begin
            sec_q <= sec_q + 6'd1;
          end
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
      case (mode_q)
        NORMAL: begin
          if (setPulse) mode_q <= RESET_SEC;
        end
        RESET_SEC: begin
          if (setPulse) begin
            mode_q <= SET_MIN;
          end else if (upPulse) begin
            sec_q   <= '0;
            presc_q <= '0;
          end
        end
        SET_MIN: begin
          if (setPulse)     mode_q <= SET_HOUR;
          else if (upPulse) min_q  <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        end
        default: begin
          // Returning to NORMAL restarts the time on an exact minute.
          if (setPulse) begin
            mode_q  <= NORMAL;
            sec_q   <= '0;
            presc_q <= '0;
          end else if (upPulse) begin
            hr_q <= (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
          end
        end
      endcase
    end
  end

  // Free-running blink phase and digit scanner; neither depends on mode.
  always_ff @(posedge i_Clock or negedge rstInt_n) begin
    if (!rstInt_n) begin
      blink_q   <= '0;
      scanCnt_q <= '0;
      scanIdx_q <= '0;
    end else begin
      blink_q <= (blink_q == PW'(CLK_HZ - 1)) ? '0 : blink_q + PW'(1);
      if (scanCnt_q == SW'(SCAN_CYCLES - 1)) begin
        scanCnt_q <= '0;
        scanIdx_q <= scanIdx_q + 2'd1;
      end else begin
        scanCnt_q <= scanCnt_q + SW'(1);
      end
    end
  end

  function automatic logic [6:0] decodeDigit(input logic [3:0] v);
    case (v)
      4'd0:    decodeDigit = 7'b0111111;
      4'd1:    decodeDigit = 7'b0000110;
      4'd2:    decodeDigit = 7'b1011011;
      4'd3:    decodeDigit = 7'b1001111;
      4'd4:    decodeDigit = 7'b1100110;
      4'd5:    decodeDigit = 7'b1101101;
      4'd6:    decodeDigit = 7'b1111101;
      4'd7:    decodeDigit = 7'b0000111;
      4'd8:    decodeDigit = 7'b1111111;
      4'd9:    decodeDigit = 7'b1101111;
      default: decodeDigit = 7'b0000000;
    endcase
  endfunction

  assign blinkOff = (blink_q >= PW'(CLK_HZ / 2));

  // Select the value for the scanned digit and decide blanking and dot.
  always_comb begin
    digVal = 4'd0;
    blank  = 1'b0;
    dot    = 1'b0;
    case (scanIdx_q)
      2'd0:    digVal = (mode_q == RESET_SEC) ? 4'(sec_q % 6'd10) : 4'(min_q % 6'd10);
      2'd1:    digVal = (mode_q == RESET_SEC) ? 4'(sec_q / 6'd10) : 4'(min_q / 6'd10);
      2'd2:    digVal = 4'(hr_q % 5'd10);
      default: digVal = 4'(hr_q / 5'd10);
    endcase
    if (mode_q == RESET_SEC && scanIdx_q[1])             blank = 1'b1;
    if (mode_q == SET_MIN   && !scanIdx_q[1] && blinkOff) blank = 1'b1;
    if (mode_q == SET_HOUR  && scanIdx_q[1]  && blinkOff) blank = 1'b1;
`ifdef COLON_BLINK_EN
    dot = (mode_q == NORMAL) && (scanIdx_q == 2'd2) && (presc_q < PW'(CLK_HZ / 2));
`else
    dot = 1'b0;
`endif
    digits_d   = blank ? 4'b0000 : (4'b0001 << scanIdx_q);
    segments_d = blank ? 8'h00 : {dot, decodeDigit(digVal)};
  end

  always_ff @(posedge i_Clock or negedge rstInt_n) begin
    if (!rstInt_n) begin
      o_Digits   <= 4'b0001;
      o_Segments <= 8'b00111111;
    end else begin
      o_Digits   <= digits_d;
      o_Segments <= segments_d;
    end
  end

endmodule

// File: tb/tb_clock_display_top.sv
// Self-checking bench for clock_display_top with shrunken timing parameters.
module tb_clock_display_top;

  localparam int CLK_HZ = 64;
  localparam int DEB    = 16;
  localparam int SCAN   = 4;
  localparam int WIN    = 2 * CLK_HZ;
  localparam int READ   = 4 * SCAN + 4;
`ifdef COLON_BLINK_EN
  localparam int EXP_DOT = 16;
`else
  localparam int EXP_DOT = 0;
`endif

  typedef struct {
    string name;
    int    cnt3, cnt2, cnt1, cnt0;
    int    dots;
  } modeVec_t;

  typedef struct {
    int minUps;
    int hourUps;
    int expTime;
  } setVec_t;

  logic       i_Clock, i_Reset_n, i_Button_Set, i_Button_Up;
  logic [7:0] o_Segments;
  logic [3:0] o_Digits;

  int checksTotal, checksPassed;
  int onCnt[4];
  int dig[4];
  int dotCnt, dotMisplaced, badHot;
  logic [6:0] segTable[10];
  modeVec_t modeVecs[4];
  setVec_t  setVecs[4];
  int modelH, modelM, t;

  clock_display_top #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .i_Clock     (i_Clock),
    .i_Reset_n   (i_Reset_n),
    .i_Button_Set(i_Button_Set),
    .i_Button_Up (i_Button_Up),
    .o_Segments  (o_Segments),
    .o_Digits    (o_Digits)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checksTotal++;
    if (actual == expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input bit setB, input bit upB, input int highCycles, input int lowCycles);
    i_Button_Set = setB;
    i_Button_Up  = upB;
    waitCycles(highCycles);
    i_Button_Set = 1'b0;
    i_Button_Up  = 1'b0;
    waitCycles(lowCycles);
  endtask

  task automatic pressButton(input bit setB, input bit upB);
    applyStimulus(setB, upB, DEB + 8, DEB + 8);
  endtask

  function automatic int decodeSeg(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (s == segTable[i]) return i;
    return -1;
  endfunction

  // Watch the display for a number of cycles, recording per-digit enable
  // counts, the last digit value shown at each position and dot behaviour.
  task automatic observe(input int cycles);
    for (int i = 0; i < 4; i++) begin
      onCnt[i] = 0;
      dig[i]   = -2;
    end
    dotCnt = 0;
    dotMisplaced = 0;
    badHot = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge i_Clock);
      if ($countones(o_Digits) > 1) badHot++;
      for (int i = 0; i < 4; i++) begin
        if (o_Digits[i]) begin
          onCnt[i]++;
          dig[i] = decodeSeg(o_Segments[6:0]);
        end
      end
      if (o_Segments[7]) begin
        dotCnt++;
        if (o_Digits != 4'b0100) dotMisplaced++;
      end
    end
  endtask

  task automatic readTime(output int hhmm);
    observe(READ);
    if (dig[0] < 0 || dig[1] < 0 || dig[2] < 0 || dig[3] < 0) hhmm = -1;
    else hhmm = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
  endtask

  task automatic doReset();
    i_Reset_n = 1'b0;
    waitCycles(4);
    i_Reset_n = 1'b1;
    waitCycles(2);
  endtask

  task automatic checkModeCounts(input modeVec_t v);
    observe(WIN);
    checkOutput({v.name, "_dig3"}, onCnt[3], v.cnt3);
    checkOutput({v.name, "_dig2"}, onCnt[2], v.cnt2);
    checkOutput({v.name, "_dig1"}, onCnt[1], v.cnt1);
    checkOutput({v.name, "_dig0"}, onCnt[0], v.cnt0);
    checkOutput({v.name, "_dots"}, dotCnt, v.dots);
    checkOutput({v.name, "_onehot"}, badHot, 0);
  endtask

  initial begin
    segTable[0] = 7'h3F; segTable[1] = 7'h06; segTable[2] = 7'h5B;
    segTable[3] = 7'h4F; segTable[4] = 7'h66; segTable[5] = 7'h6D;
    segTable[6] = 7'h7D; segTable[7] = 7'h07; segTable[8] = 7'h7F;
    segTable[9] = 7'h6F;

    modeVecs[0] = '{"reset_sec", 0,  0,  32, 32, 0};
    modeVecs[1] = '{"set_min",   32, 32, 16, 16, 0};
    modeVecs[2] = '{"set_hour",  16, 16, 32, 32, 0};
    modeVecs[3] = '{"normal",    32, 32, 32, 32, EXP_DOT};

    setVecs[0] = '{34, 12, 1234};
    setVecs[1] = '{60, 5,  500};
    setVecs[2] = '{1,  25, 101};
    setVecs[3] = '{59, 23, 2359};

    checksTotal  = 0;
    checksPassed = 0;
    i_Reset_n    = 1'b0;
    i_Button_Set = 1'b0;
    i_Button_Up  = 1'b0;

    // Reset values, then a clean scan of 00:00.
    waitCycles(3);
    checkOutput("reset_digits", int'(o_Digits), 1);
    checkOutput("reset_segments", int'(o_Segments), 8'h3F);
    i_Reset_n = 1'b1;
    waitCycles(100);
    checkModeCounts(modeVecs[3]);
    checkOutput("normal_dot_position", dotMisplaced, 0);
    checkOutput("reset_time", (dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0]), 0);

    // Walk through every mode with single Set presses.
    for (int i = 0; i < 4; i++) begin
      pressButton(1'b1, 1'b0);
      checkModeCounts(modeVecs[i]);
      if (i == 0) begin
        pressButton(1'b0, 1'b1);
        observe(READ);
        checkOutput("sec_tens_cleared", dig[1], 0);
        checkOutput("sec_units_cleared", dig[0], 0);
        checkOutput("hr_tens_hidden", dig[3], -2);
        checkOutput("hr_units_hidden", dig[2], -2);
      end
    end

    // Time-setting vectors, each from a fresh reset.
    foreach (setVecs[i]) begin
      doReset();
      pressButton(1'b1, 1'b0);
      pressButton(1'b1, 1'b0);
      for (int k = 0; k < setVecs[i].minUps; k++) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      for (int k = 0; k < setVecs[i].hourUps; k++) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      readTime(t);
      checkOutput($sformatf("set_vec%0d", i), t, setVecs[i].expTime);
    end

    // 23:59:00 runs into midnight.
    waitCycles(3700);
    readTime(t);
    checkOutput("before_midnight", t, 2359);
    waitCycles(150);
    readTime(t);
    checkOutput("after_midnight", t, 0);

    // Set and Up together in SET_MIN: only the mode advances.
    pressButton(1'b1, 1'b0);
    pressButton(1'b1, 1'b0);
    pressButton(1'b1, 1'b1);
    pressButton(1'b0, 1'b1);
    pressButton(1'b1, 1'b0);
    readTime(t);
    checkOutput("set_beats_up", t, 100);

    // Bouncy press gives one advance; short glitches give none.
    applyStimulus(1'b1, 1'b0, 5, 3);
    applyStimulus(1'b1, 1'b0, 2, 1);
    applyStimulus(1'b1, 1'b0, 1024, DEB + 24);
    checkModeCounts(modeVecs[0]);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 10, 10);
    waitCycles(DEB + 8);
    checkModeCounts(modeVecs[0]);

    // One minute from reset, then an asynchronous reset mid-count.
    doReset();
    waitCycles(3780);
    readTime(t);
    checkOutput("minute_not_yet", t, 0);
    waitCycles(100);
    readTime(t);
    checkOutput("one_minute", t, 1);
    @(negedge i_Clock);
    #2 i_Reset_n = 1'b0;
    #1;
    checkOutput("midreset_digits", int'(o_Digits), 1);
    checkOutput("midreset_segments", int'(o_Segments), 8'h3F);
    waitCycles(3);
    i_Reset_n = 1'b1;
    waitCycles(2);

    // Random setting rounds against a plain HH:MM model.
    modelH = 0;
    modelM = 0;
    for (int r = 0; r < 5; r++) begin
      int nMin, nHour;
      nMin  = $urandom_range(0, 15);
      nHour = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      for (int k = 0; k < nMin; k++) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      for (int k = 0; k < nHour; k++) pressButton(1'b0, 1'b1);
      pressButton(1'b1, 1'b0);
      modelM = (modelM + nMin) % 60;
      modelH = (modelH + nHour) % 24;
      readTime(t);
      checkOutput($sformatf("rand_round%0d", r), t, modelH * 100 + modelM);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
